// File: rtl/arcade_mem_pkg.sv
// Shared types and decode helpers for the arcade CPU memory map.
// Provides the FSM state enum, download window bases and region-hit check.
package arcade_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    LOAD
  } mem_state_t;

  localparam logic [15:0] DN_ROM1_BASE  = 16'h2000;
  localparam logic [15:0] DN_CPROM_BASE = 16'h3000;

  // Base is aligned to 2**aw, so a hit is a match above the region bits.
  function automatic logic region_hit(
    input logic [15:0] a,
    input logic [15:0] base,
    input int unsigned aw
  );
    return (a >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/arcade_memory_map_clear_seq.sv
// RAM clear sequencer: walks every RAM address writing CLEAR_VAL.
// Ports: i_clk/i_rst, i_active, CPU write port in, o_done, RAM port out.
module mem_clear_seq
  import arcade_mem_pkg::*;
#(
  parameter int          RAM_AW    = 13,
  parameter logic [7:0]  CLEAR_VAL = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_active,
  input  logic              i_cpu_we,
  input  logic [RAM_AW-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_din,
  output logic              o_done,
  output logic              o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [7:0]        o_ram_din
);

  logic [RAM_AW-1:0] r_clr_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_clr_addr <= '0;
    else if (i_active) r_clr_addr <= r_clr_addr + 1'b1;
  end

  assign o_done     = i_active & (&r_clr_addr);
  assign o_ram_we   = i_active | i_cpu_we;
  assign o_ram_addr = i_active ? r_clr_addr : i_cpu_addr;
  assign o_ram_din  = i_active ? CLEAR_VAL : i_cpu_din;

endmodule

// File: rtl/dpram.sv
// Simple dual-port RAM: port a writes, port b reads with 1-cycle latency.
// Ports: clk, we_a/addr_a/d_a (write side), addr_b/q_b (read side).
module dpram #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] d_a,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] q_b
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_a) r_mem[addr_a] <= d_a;
    q_b <= r_mem[addr_b];
  end

endmodule

// File: rtl/spram.sv
// Single-port RAM, synchronous read returning old data on a write.
// Ports: clk, we, addr, d (write data), q (read data, 1-cycle latency).
module spram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= d;
    q <= r_mem[addr];
  end

endmodule

// File: rtl/arcade_memory_map.sv
// CPU memory map: two program ROMs, work RAM, colour PROM, download FSM.
// Ports: CPU bus, video PROM read, HPS download stream, busy/count status.
module arcade_memory_map
  import arcade_mem_pkg::*;
#(
  parameter int          ROM0_AW   = 13,
  parameter int          ROM1_AW   = 12,
  parameter logic [15:0] ROM1_BASE = 16'h4000,
  parameter int          RAM_AW    = 13,
  parameter int          CPROM_AW  = 11,
  parameter logic [7:0]  CLEAR_VAL = 8'h00
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                RW_n,
  input  logic [15:0]         Addr,
  input  logic [15:0]         Ram_Addr,
  input  logic [7:0]          Ram_in,
  output logic [7:0]          Ram_out,
  output logic [7:0]          Rom_out,
  output logic                rom_valid,
  input  logic [CPROM_AW-1:0] color_prom_addr,
  output logic [7:0]          color_prom_out,
  input  logic [15:0]         dn_addr,
  input  logic [7:0]          dn_data,
  input  logic                dn_wr,
  input  logic                dn_download,
  output logic                mem_busy,
  output logic [15:0]         dn_count
);

  mem_state_t  r_state;
  logic        r_busy;
  logic        r_valid;
  logic [15:0] r_cnt;
  logic        r_dn_prev;
  logic        r_sel0;
  logic        r_sel1;

  logic w_load;
  logic w_dn0;
  logic w_dn1;
  logic w_dnc;
  logic w_dn_acc;
  logic w_dn_rise;
  logic w_hit0;
  logic w_hit1;
  logic w_clr_done;
  logic [7:0] w_q0;
  logic [7:0] w_q1;
  logic w_ram_we;
  logic [RAM_AW-1:0] w_ram_addr;
  logic [7:0] w_ram_din;
  logic w_unused;

  assign w_unused = &{1'b0, Ram_Addr[15:RAM_AW]};

  assign w_load    = (r_state == LOAD);
  assign w_dn0     = region_hit(dn_addr, 16'h0000, ROM0_AW);
  assign w_dn1     = region_hit(dn_addr, DN_ROM1_BASE, ROM1_AW);
  assign w_dnc     = region_hit(dn_addr, DN_CPROM_BASE, CPROM_AW);
  assign w_dn_acc  = dn_wr & w_load & (w_dn0 | w_dn1 | w_dnc);
  assign w_dn_rise = dn_download & ~r_dn_prev;
  assign w_hit0    = region_hit(Addr, 16'h0000, ROM0_AW);
  assign w_hit1    = region_hit(Addr, ROM1_BASE, ROM1_AW);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= CLEAR;
      r_busy    <= 1'b1;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
      r_dn_prev <= 1'b0;
      r_sel0    <= 1'b0;
      r_sel1    <= 1'b0;
    end else begin
      r_dn_prev <= dn_download;
      r_sel0    <= w_hit0;
      r_sel1    <= w_hit1;
      unique case (r_state)
        CLEAR: begin
          if (w_clr_done) begin
            r_state <= dn_download ? LOAD : IDLE;
            r_busy  <= dn_download;
            r_valid <= ~dn_download;
          end
        end
        IDLE: begin
          if (w_dn_rise) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_cnt   <= '0;
          end
        end
        LOAD: begin
          if (w_dn_acc && r_cnt != 16'hFFFF)
            r_cnt <= r_cnt + 16'd1;
          if (!dn_download) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign mem_busy  = r_busy;
  assign rom_valid = r_valid;
  assign dn_count  = r_cnt;
  assign Rom_out   = r_sel0 ? w_q0 : (r_sel1 ? w_q1 : 8'h00);

  mem_clear_seq #(
    .RAM_AW   (RAM_AW),
    .CLEAR_VAL(CLEAR_VAL)
  ) u_clr (
    .i_clk     (Clock),
    .i_rst     (Reset),
    .i_active  (r_state == CLEAR),
    .i_cpu_we  (~RW_n && r_state == IDLE),
    .i_cpu_addr(Ram_Addr[RAM_AW-1:0]),
    .i_cpu_din (Ram_in),
    .o_done    (w_clr_done),
    .o_ram_we  (w_ram_we),
    .o_ram_addr(w_ram_addr),
    .o_ram_din (w_ram_din)
  );

  dpram #(.AW(ROM0_AW), .DW(8)) u_rom0 (
    .clk   (Clock),
    .we_a  (dn_wr & w_load & w_dn0),
    .addr_a(dn_addr[ROM0_AW-1:0]),
    .d_a   (dn_data),
    .addr_b(Addr[ROM0_AW-1:0]),
    .q_b   (w_q0)
  );

  dpram #(.AW(ROM1_AW), .DW(8)) u_rom1 (
    .clk   (Clock),
    .we_a  (dn_wr & w_load & w_dn1),
    .addr_a(dn_addr[ROM1_AW-1:0]),
    .d_a   (dn_data),
    .addr_b(Addr[ROM1_AW-1:0]),
    .q_b   (w_q1)
  );

  dpram #(.AW(CPROM_AW), .DW(8)) u_cprom (
    .clk   (Clock),
    .we_a  (dn_wr & w_load & w_dnc),
    .addr_a(dn_addr[CPROM_AW-1:0]),
    .d_a   (dn_data),
    .addr_b(color_prom_addr),
    .q_b   (color_prom_out)
  );

  spram #(.AW(RAM_AW), .DW(8)) u_ram (
    .clk (Clock),
    .we  (w_ram_we),
    .addr(w_ram_addr),
    .d   (w_ram_din),
    .q   (Ram_out)
  );

endmodule

// File: tb/tb_arcade_memory_map.sv
// Directed bench for arcade_memory_map with default parameters.
// Each scenario task checks its own expectations inline.
module tb_arcade_memory_map;

  localparam int NRAM = 8192;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        RW_n;
  logic [15:0] Addr;
  logic [15:0] Ram_Addr;
  logic [7:0]  Ram_in;
  logic [7:0]  Ram_out;
  logic [7:0]  Rom_out;
  logic        rom_valid;
  logic [10:0] color_prom_addr;
  logic [7:0]  color_prom_out;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        dn_download;
  logic        mem_busy;
  logic [15:0] dn_count;

  int passed = 0;
  int total  = 0;

  arcade_memory_map dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .RW_n           (RW_n),
    .Addr           (Addr),
    .Ram_Addr       (Ram_Addr),
    .Ram_in         (Ram_in),
    .Ram_out        (Ram_out),
    .Rom_out        (Rom_out),
    .rom_valid      (rom_valid),
    .color_prom_addr(color_prom_addr),
    .color_prom_out (color_prom_out),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_download    (dn_download),
    .mem_busy       (mem_busy),
    .dn_count       (dn_count)
  );

  always #5 Clock = ~Clock;

  task automatic dn_write(input logic [15:0] a, input logic [7:0] d);
    dn_addr = a;
    dn_data = d;
    dn_wr   = 1'b1;
    @(negedge Clock);
  endtask

  task automatic rom_read(input logic [15:0] a,
                          output logic [7:0] d, output logic v);
    Addr = a;
    @(negedge Clock);
    d = Rom_out;
    v = rom_valid;
  endtask

  task automatic cprom_read(input logic [10:0] a, output logic [7:0] d);
    color_prom_addr = a;
    @(negedge Clock);
    d = color_prom_out;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (mem_busy === 1'b1 && n < 20000) begin
      n++;
      @(negedge Clock);
    end
    RW_n = 1'b1;
  endtask

  task automatic test_reset;
    int n;
    int errs;
    Reset = 1'b1; RW_n = 1'b0;
    Ram_Addr = 16'h0100; Ram_in = 8'hEE;
    Addr = 16'h0000; color_prom_addr = '0;
    dn_addr = '0; dn_data = '0; dn_wr = 1'b0; dn_download = 1'b0;
    @(negedge Clock);
    total++;
    if (mem_busy !== 1'b1 || rom_valid !== 1'b0)
      $display("FAIL reset_flags: busy=%b valid=%b want 1 0",
               mem_busy, rom_valid);
    else passed++;
    total++;
    if (Rom_out !== 8'h00 || dn_count !== 16'h0000)
      $display("FAIL reset_vals: rom=%h cnt=%h want 00 0000",
               Rom_out, dn_count);
    else passed++;
    Reset = 1'b0;
    count_busy(n);
    total++;
    if (n != NRAM) $display("FAIL clear_len: got %0d want %0d", n, NRAM);
    else passed++;
    total++;
    if (rom_valid !== 1'b1)
      $display("FAIL valid_idle: got %b want 1", rom_valid);
    else passed++;
    errs = 0;
    Ram_Addr = 16'h0000;
    for (int i = 1; i <= NRAM; i++) begin
      @(negedge Clock);
      if (Ram_out !== 8'h00) errs++;
      if (i < NRAM) Ram_Addr = i[15:0];
    end
    total++;
    if (errs != 0) $display("FAIL ram_clear: got %0d bad words want 0", errs);
    else passed++;
    Ram_Addr = 16'h0100;
    @(negedge Clock);
    total++;
    if (Ram_out !== 8'h00)
      $display("FAIL clear_cpu_wr: got %h want 00", Ram_out);
    else passed++;
  endtask

  task automatic test_rom_download;
    logic [7:0] d;
    logic v;
    dn_download = 1'b1;
    @(negedge Clock);
    total++;
    if (mem_busy !== 1'b1 || rom_valid !== 1'b0)
      $display("FAIL load_busy: busy=%b valid=%b want 1 0",
               mem_busy, rom_valid);
    else passed++;
    for (int i = 0; i < 4096; i++) dn_write(i[15:0], i[7:0]);
    for (int i = 0; i < 4096; i++) dn_write(16'h2000 + i[15:0], i[7:0]);
    dn_wr = 1'b0;
    total++;
    if (dn_count !== 16'h2000)
      $display("FAIL dn_count: got %h want 2000", dn_count);
    else passed++;
    dn_download = 1'b0;
    @(negedge Clock);
    total++;
    if (mem_busy !== 1'b0) $display("FAIL load_end: busy=%b want 0", mem_busy);
    else passed++;
    rom_read(16'h0010, d, v);
    total++;
    if (d !== 8'h10 || v !== 1'b1)
      $display("FAIL rom0_0010: got %h/%b want 10/1", d, v);
    else passed++;
    rom_read(16'h4010, d, v);
    total++;
    if (d !== 8'h10 || v !== 1'b1)
      $display("FAIL rom1_4010: got %h/%b want 10/1", d, v);
    else passed++;
    rom_read(16'h4FFF, d, v);
    total++;
    if (d !== 8'hFF) $display("FAIL rom1_4fff: got %h want ff", d);
    else passed++;
    rom_read(16'h0FFF, d, v);
    total++;
    if (d !== 8'hFF) $display("FAIL rom0_0fff: got %h want ff", d);
    else passed++;
  endtask

  task automatic test_decode_boundary;
    logic [7:0] d;
    logic v;
    dn_download = 1'b1;
    @(negedge Clock);
    dn_write(16'h1FFF, 8'h5A);
    dn_write(16'h3800, 8'h11);
    dn_write(16'h4000, 8'h22);
    dn_wr = 1'b0;
    total++;
    if (dn_count !== 16'h0001)
      $display("FAIL dn_window: got %h want 0001", dn_count);
    else passed++;
    dn_download = 1'b0;
    @(negedge Clock);
    rom_read(16'h1FFF, d, v);
    total++;
    if (d !== 8'h5A) $display("FAIL rom_1fff: got %h want 5a", d);
    else passed++;
    rom_read(16'h2000, d, v);
    total++;
    if (d !== 8'h00 || v !== 1'b1)
      $display("FAIL miss_2000: got %h/%b want 00/1", d, v);
    else passed++;
    rom_read(16'h5000, d, v);
    total++;
    if (d !== 8'h00) $display("FAIL miss_5000: got %h want 00", d);
    else passed++;
    rom_read(16'h3FFF, d, v);
    total++;
    if (d !== 8'h00) $display("FAIL miss_3fff: got %h want 00", d);
    else passed++;
  endtask

  task automatic test_cprom;
    logic [7:0] d;
    dn_download = 1'b1;
    @(negedge Clock);
    dn_write(16'h3123, 8'hA5);
    dn_wr = 1'b0;
    dn_download = 1'b0;
    @(negedge Clock);
    cprom_read(11'h123, d);
    total++;
    if (d !== 8'hA5) $display("FAIL cprom_123: got %h want a5", d);
    else passed++;
    dn_write(16'h3123, 8'h77);
    dn_wr = 1'b0;
    @(negedge Clock);
    total++;
    if (color_prom_out !== 8'hA5)
      $display("FAIL cprom_idle_wr: got %h want a5", color_prom_out);
    else passed++;
    total++;
    if (dn_count !== 16'h0001)
      $display("FAIL cnt_idle_wr: got %h want 0001", dn_count);
    else passed++;
  endtask

  task automatic test_ram_rw;
    Ram_Addr = 16'h2400;
    Ram_in   = 8'h3C;
    RW_n     = 1'b0;
    @(negedge Clock);
    total++;
    if (Ram_out !== 8'h00) $display("FAIL ram_rdw: got %h want 00", Ram_out);
    else passed++;
    RW_n = 1'b1;
    @(negedge Clock);
    total++;
    if (Ram_out !== 8'h3C) $display("FAIL ram_rd: got %h want 3c", Ram_out);
    else passed++;
    Ram_Addr = 16'h0400;
    @(negedge Clock);
    total++;
    if (Ram_out !== 8'h3C) $display("FAIL ram_alias: got %h want 3c", Ram_out);
    else passed++;
  endtask

  task automatic test_reset_mid_download;
    int n;
    logic [7:0] d;
    logic v;
    dn_download = 1'b1;
    @(negedge Clock);
    for (int i = 0; i < 300; i++) dn_write(16'h3200 + i[15:0], ~i[7:0]);
    dn_wr = 1'b0;
    total++;
    if (dn_count !== 16'd300)
      $display("FAIL cnt_300: got %0d want 300", dn_count);
    else passed++;
    Reset = 1'b1;
    dn_download = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    total++;
    if (dn_count !== 16'h0000 || mem_busy !== 1'b1)
      $display("FAIL rst_mid: cnt=%h busy=%b want 0000 1", dn_count, mem_busy);
    else passed++;
    count_busy(n);
    total++;
    if (n != NRAM) $display("FAIL clear_rerun: got %0d want %0d", n, NRAM);
    else passed++;
    rom_read(16'h0010, d, v);
    total++;
    if (d !== 8'h10) $display("FAIL keep_rom0: got %h want 10", d);
    else passed++;
    rom_read(16'h4010, d, v);
    total++;
    if (d !== 8'h10) $display("FAIL keep_rom1: got %h want 10", d);
    else passed++;
    cprom_read(11'h123, d);
    total++;
    if (d !== 8'hA5) $display("FAIL keep_cprom: got %h want a5", d);
    else passed++;
    cprom_read(11'h205, d);
    total++;
    if (d !== 8'hFA) $display("FAIL keep_partial: got %h want fa", d);
    else passed++;
    repeat (5) @(negedge Clock);
    total++;
    if (mem_busy !== 1'b0)
      $display("FAIL stay_idle: busy=%b want 0", mem_busy);
    else passed++;
    dn_download = 1'b1;
    @(negedge Clock);
    total++;
    if (mem_busy !== 1'b1 || dn_count !== 16'h0000)
      $display("FAIL reload: busy=%b cnt=%h want 1 0000", mem_busy, dn_count);
    else passed++;
    dn_download = 1'b0;
    @(negedge Clock);
  endtask

  initial begin
    test_reset;
    test_rom_download;
    test_decode_boundary;
    test_cprom;
    test_ram_rw;
    test_reset_mid_download;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
